mesh_link_arbiter: RTL and testbench

Round-robin arbiter sharing one router output FIFO among `N_REQ` requesting input FIFOs inside the mesh. It issues pops and pushes with a credit check against the downstream FIFO occupancy, so the push-at-full overflow flagged by the mesh overflow monitor cannot occur on an arbitrated link. It sits between the per-terminal input FIFOs (pndng/pop/Dout style) and a single `fifo_out` of a router interface.

---
 rtl/mesh_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 39 +++
 rtl/mesh_link_arbiter.sv | 109 ++++++++++
 tb/tb_mesh_link_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_arb_pkg.sv
// Shared constants, width helper and grant index type for the mesh link arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mesh_arb_pkg;

    localparam int STALL_W   = 16;
    localparam int N_REQ_DEF = 4;

    // Width of a FIFO occupancy count able to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [$clog2(N_REQ_DEF)-1:0] grant_t;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set bit of elig_i strictly after ptr_i, cyclically.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies found_o with its own credit check.
// Ports: elig_i (eligible vector), ptr_i (last winner), found_o (any eligible), idx_o (winner).
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  elig_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             pos;
    int             sum;

    always_comb begin
        // Rotate so that bit 0 of rot corresponds to index ptr_i+1.
        dbl = {elig_i, elig_i} >> (int'(ptr_i) + 1);
        rot = dbl[N-1:0];
        pos = 0;
        // Descending scan leaves the lowest set position in pos.
        for (int p = N - 1; p >= 0; p--) begin
            if (rot[p]) begin
                pos = p;
            end
        end
        sum = int'(ptr_i) + 1 + pos;
        if (sum >= N) begin
            sum = sum - N;
        end
        found_o = |elig_i;
        idx_o   = sum[IW-1:0];
    end

endmodule

// File: rtl/mesh_link_arbiter.sv
// Round-robin arbiter popping N_REQ input FIFOs into one downstream router FIFO.
// Latency: pop in cycle t (combinational), push/data_out registered in cycle t+1; 1 word/cycle sustained.
// Backpressure: pops only while out_count + push_out + 1 <= fifo_depth; blocked cycles counted in stall_cnt.
// Ports: pndng_in/data_in/req_mask from requesters, out_count from downstream FIFO,
//        pop_out to requesters, push_out/data_out to downstream, grant_id/stall_cnt status.
module mesh_link_arbiter
    import mesh_arb_pkg::*;
#(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4,
    parameter int N_REQ      = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_REQ-1:0]                    pndng_in,
    input  logic [N_REQ-1:0][pckg_sz-1:0]       data_in,
    input  logic [N_REQ-1:0]                    req_mask,
    input  logic [cnt_w(fifo_depth)-1:0]        out_count,
    output logic [N_REQ-1:0]                    pop_out,
    output logic                                push_out,
    output logic [pckg_sz-1:0]                  data_out,
    output logic [$clog2(N_REQ)-1:0]            grant_id,
    output logic [STALL_W-1:0]                  stall_cnt
);

    localparam int CW = cnt_w(fifo_depth);
    localparam int IW = $clog2(N_REQ);
    localparam int SW = CW + 1;

    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic               push_q, push_d;
    logic [pckg_sz-1:0] data_q, data_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic [N_REQ-1:0]   elig;
    logic               found;
    logic [IW-1:0]      pick_idx;
    logic [SW-1:0]      credit_sum;
    logic               credit_ok;
    logic               grant;

    assign elig = pndng_in & req_mask;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .elig_i  (elig),
        .ptr_i   (rr_ptr_q),
        .found_o (found),
        .idx_o   (pick_idx)
    );

    // One extra bit so the sum cannot wrap. The push_q term accounts for the
    // word leaving our pipeline register this cycle, which out_count has not
    // seen yet. A concurrent downstream pop is deliberately ignored.
    assign credit_sum = {1'b0, out_count} + SW'(push_q) + SW'(1);
    assign credit_ok  = credit_sum <= SW'(fifo_depth);
    assign grant      = found && credit_ok && !reset;

    always_comb begin
        pop_out = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant && (pick_idx == IW'(i))) begin
                pop_out[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        push_d   = grant;
        stall_d  = stall_q;
        if (grant) begin
            rr_ptr_d = pick_idx;
            grant_d  = pick_idx;
            data_d   = data_in[pick_idx];
        end
        if (found && !credit_ok && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // rr_ptr starts at the last index so requester 0 wins first.
            rr_ptr_q <= IW'(N_REQ - 1);
            grant_q  <= '0;
            push_q   <= 1'b0;
            data_q   <= '0;
            stall_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            push_q   <= push_d;
            data_q   <= data_d;
            stall_q  <= stall_d;
        end
    end

    assign push_out  = push_q;
    assign data_out  = data_q;
    assign grant_id  = grant_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_mesh_link_arbiter.sv
// Scoreboard bench for mesh_link_arbiter: directed vectors, expected pushes queued, monitor compares.
// Latency: checks pop_out in the grant cycle and push_out/data_out/grant_id one cycle later.
// Backpressure: drives out_count directly to exercise credit blocking.
module tb_mesh_link_arbiter;
    import mesh_arb_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [3:0]           pndng_in;
    logic [3:0][39:0]     data_in;
    logic [3:0]           req_mask;
    logic [2:0]           out_count;
    logic [3:0]           pop_out;
    logic                 push_out;
    logic [39:0]          data_out;
    logic [1:0]           grant_id;
    logic [15:0]          stall_cnt;

    typedef struct {
        logic [39:0] dat;
        grant_t      id;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    mesh_link_arbiter #(
        .pckg_sz    (40),
        .fifo_depth (4),
        .N_REQ      (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pndng_in  (pndng_in),
        .data_in   (data_in),
        .req_mask  (req_mask),
        .out_count (out_count),
        .pop_out   (pop_out),
        .push_out  (push_out),
        .data_out  (data_out),
        .grant_id  (grant_id),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic grant_t oh2idx(input logic [3:0] oh);
        grant_t r = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) r = grant_t'(i);
        end
        return r;
    endfunction

    // Monitor: runs just after the falling edge so the stimulus side has queued
    // any grant made in the current cycle before the comparison.
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
                checks++;
                if (push_out !== 1'b1 || data_out !== sb[0].dat || grant_id !== sb[0].id) begin
                    errors++;
                    $display("FAIL push: got push=%0b data=%0h id=%0d expected push=1 data=%0h id=%0d",
                             push_out, data_out, grant_id, sb[0].dat, sb[0].id);
                end
                void'(sb.pop_front());
            end else if (push_out !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_push: got push=%0b data=%0h expected push=0", push_out, data_out);
            end
        end
    end

    // Called at posedge+1; leaves the bench at the next posedge+1.
    task automatic step(input logic [3:0] pnd, input logic [3:0] msk, input logic [2:0] cnt,
                        input logic [3:0] exp_pop);
        exp_t e;
        pndng_in  = pnd;
        req_mask  = msk;
        out_count = cnt;
        @(negedge clk);
        chk("pop_out", 64'(pop_out), 64'(exp_pop));
        if (exp_pop != 4'b0000) begin
            e.dat = data_in[oh2idx(exp_pop)];
            e.id  = oh2idx(exp_pop);
            e.cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset     = 1'b1;
        pndng_in  = 4'b0000;
        req_mask  = 4'b1111;
        out_count = 3'd0;
        sb.delete();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        pndng_in = 4'b0000;
        @(negedge clk);
        chk({tag, "_pop"},   64'(pop_out),   64'd0);
        chk({tag, "_push"},  64'(push_out),  64'd0);
        chk({tag, "_data"},  64'(data_out),  64'd0);
        chk({tag, "_gid"},   64'(grant_id),  64'd0);
        chk({tag, "_stall"}, 64'(stall_cnt), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        data_in[0] = 40'h11_0000_00AA;
        data_in[1] = 40'h22_0000_00BB;
        data_in[2] = 40'h33_0000_00CC;
        data_in[3] = 40'h44_0000_00DD;
        reset      = 1'b1;
        pndng_in   = 4'b0000;
        req_mask   = 4'b1111;
        out_count  = 3'd0;
        @(posedge clk);
        #1;

        // Reset state
        do_reset(2);
        chk_idle_outputs("rst");

        // Single requester
        step(4'b0001, 4'b1111, 3'd0, 4'b0001);
        step(4'b0000, 4'b1111, 3'd0, 4'b0000);

        // All requesting: 0,1,2,3,0 back to back
        do_reset(2);
        step(4'b1111, 4'b1111, 3'd0, 4'b0001);
        step(4'b1111, 4'b1111, 3'd0, 4'b0010);
        step(4'b1111, 4'b1111, 3'd0, 4'b0100);
        step(4'b1111, 4'b1111, 3'd0, 4'b1000);
        step(4'b1111, 4'b1111, 3'd0, 4'b0001);
        step(4'b0000, 4'b1111, 3'd0, 4'b0000);

        // Downstream full for 10 cycles
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, 4'b1111, 3'd4, 4'b0000);
        end
        pndng_in = 4'b0000;
        @(negedge clk);
        chk("stall_full", 64'(stall_cnt), 64'd10);
        @(posedge clk);
        #1;

        // Credit with push in flight
        do_reset(2);
        step(4'b0001, 4'b1111, 3'd0, 4'b0001);
        step(4'b0001, 4'b1111, 3'd3, 4'b0000);
        pndng_in  = 4'b0001;
        out_count = 3'd3;
        @(negedge clk);
        chk("stall_inflight", 64'(stall_cnt), 64'd1);
        @(posedge clk);
        #1;
        // The cycle above already popped (push_q was 0); stimulus held, so re-check
        // the same grant through step bookkeeping would double count: instead queue it here.
        begin
            exp_t e;
            e.dat = data_in[0];
            e.id  = 2'd0;
            e.cyc = cyc - 1;
            sb.push_back(e);
        end
        step(4'b0000, 4'b1111, 3'd0, 4'b0000);

        // Mask: requester 2 skipped
        do_reset(2);
        step(4'b1111, 4'b1011, 3'd0, 4'b0001);
        step(4'b1111, 4'b1011, 3'd0, 4'b0010);
        step(4'b1111, 4'b1011, 3'd0, 4'b1000);
        step(4'b1111, 4'b1011, 3'd0, 4'b0001);
        step(4'b0000, 4'b1111, 3'd0, 4'b0000);

        // Reset mid-operation
        do_reset(2);
        step(4'b0011, 4'b1111, 3'd0, 4'b0001);
        step(4'b0011, 4'b1111, 3'd0, 4'b0010);
        do_reset(1);
        chk_idle_outputs("midrst");
        step(4'b0011, 4'b1111, 3'd0, 4'b0001);
        step(4'b0000, 4'b1111, 3'd0, 4'b0000);

        @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
